// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FSM state encoding and clog2 helper for the symmetric FIR
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// rtl/fir_round_sat.sv - round-half-up arithmetic shift and saturation to DW bits
module fir_round_sat #(
    parameter int IW    = 33,
    parameter int DW    = 16,
    parameter int SHIFT = 16
) (
    input  logic signed [IW-1:0] i_acc,
    output logic signed [DW-1:0] o_data
);

    logic signed [IW:0] w_sum;
    logic signed [IW:0] w_shifted;
    logic               w_in_range;

    // One guard bit keeps the rounding add from wrapping.
    if (SHIFT == 0) begin : g_no_round
        assign w_sum = {i_acc[IW-1], i_acc};
    end else begin : g_round
        assign w_sum = {i_acc[IW-1], i_acc} + ((IW+1)'(1) << (SHIFT - 1));
    end

    assign w_shifted  = w_sum >>> SHIFT;
    assign w_in_range = (w_shifted[IW:DW-1] == {(IW-DW+2){w_shifted[IW]}});
    assign o_data     = w_in_range   ? w_shifted[DW-1:0] :
                        w_shifted[IW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};

endmodule

// File: rtl/sym_fir_filter.sv
// rtl/sym_fir_filter.sv - symmetric FIR with one time-shared pre-adder and MAC
module sym_fir_filter
    import fir_pkg::*;
#(
    parameter int DW    = 16,
    parameter int CW    = 12,
    parameter int NTAPS = 21,
    parameter int SHIFT = 16
) (
    input  logic                                 pClk,
    input  logic                                 pRst,
    input  logic                                 pInValid,
    output logic                                 pInReady,
    input  logic signed [DW-1:0]                 pFilterIn,
    output logic                                 pOutValid,
    output logic signed [DW-1:0]                 pFilterOut,
    input  logic                                 pCoefWe,
    input  logic [clog2((NTAPS+1)/2)-1:0]        pCoefAddr,
    input  logic signed [CW-1:0]                 pCoefData
);

    localparam int HALF = (NTAPS + 1) / 2;
    localparam int AW   = clog2(HALF);
    localparam int NW   = clog2(NTAPS);
    localparam int PW   = DW + CW + 1;
    localparam int ACCW = PW + AW;

    fir_state_t             r_state;
    logic [AW-1:0]          r_tap;
    logic signed [ACCW-1:0] r_acc;
    logic signed [DW-1:0]   r_dline [NTAPS];
    logic signed [CW-1:0]   r_coef  [HALF];
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic signed [DW-1:0]   r_out;

    logic                   w_accept;
    logic                   w_coef_wr;
    logic                   w_centre;
    logic [NW-1:0]          w_lo_idx;
    logic [NW-1:0]          w_hi_idx;
    logic signed [DW-1:0]   w_x_lo;
    logic signed [DW-1:0]   w_x_hi;
    logic signed [DW:0]     w_pre;
    logic signed [CW-1:0]   w_coef;
    logic signed [PW-1:0]   w_prod;
    logic signed [DW-1:0]   w_round;

    assign w_accept  = pInValid && r_in_ready;
    assign w_coef_wr = pCoefWe && (r_state == ST_IDLE) && (int'(pCoefAddr) < HALF);
    assign w_centre  = (r_tap == AW'(HALF - 1));
    assign w_lo_idx  = NW'(r_tap);
    assign w_hi_idx  = NW'(NTAPS - 1) - NW'(r_tap);
    assign w_x_lo    = r_dline[w_lo_idx];
    assign w_x_hi    = r_dline[w_hi_idx];
    assign w_coef    = r_coef[r_tap];

    // Centre tap has no mirror partner, so it is only sign-extended.
    assign w_pre  = w_centre ? {w_x_lo[DW-1], w_x_lo}
                             : {w_x_lo[DW-1], w_x_lo} + {w_x_hi[DW-1], w_x_hi};
    assign w_prod = PW'(w_pre) * PW'(w_coef);

    fir_round_sat #(
        .IW    (ACCW),
        .DW    (DW),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .i_acc  (r_acc),
        .o_data (w_round)
    );

    always_ff @(posedge pClk) begin
        if (pRst) begin
            r_state     <= ST_IDLE;
            r_tap       <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            for (int i = 0; i < NTAPS; i++) r_dline[i] <= '0;
            for (int i = 0; i < HALF; i++)  r_coef[i]  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_coef_wr) r_coef[pCoefAddr] <= pCoefData;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        for (int i = NTAPS - 1; i > 0; i--) r_dline[i] <= r_dline[i-1];
                        r_dline[0] <= pFilterIn;
                        r_tap      <= '0;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    r_acc <= r_acc + ACCW'(w_prod);
                    if (w_centre) r_state <= ST_OUT;
                    else          r_tap   <= r_tap + AW'(1);
                end
                ST_OUT: begin
                    r_out       <= w_round;
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pInReady   = r_in_ready;
    assign pOutValid  = r_out_valid;
    assign pFilterOut = r_out;

endmodule

// File: tb/tb_sym_fir_filter.sv
// tb/tb_sym_fir_filter.sv - self-checking bench for sym_fir_filter at SHIFT 0, 1 and 16
module tb_sym_fir_filter;

    localparam int DW    = 16;
    localparam int CW    = 12;
    localparam int NTAPS = 21;
    localparam int HALF  = 11;
    localparam int AW    = 4;

    logic                 pClk = 1'b0;
    logic                 pRst;
    logic                 pInValid;
    logic signed [DW-1:0] pFilterIn;
    logic                 pCoefWe;
    logic [AW-1:0]        pCoefAddr;
    logic signed [CW-1:0] pCoefData;

    logic                 w_rdy [3];
    logic                 w_vld [3];
    logic signed [DW-1:0] w_y   [3];

    int sh_of [3] = '{0, 1, 16};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sym_fir_filter #(
            .DW    (DW),
            .CW    (CW),
            .NTAPS (NTAPS),
            .SHIFT ((g == 0) ? 0 : ((g == 1) ? 1 : 16))
        ) u_dut (
            .pClk       (pClk),
            .pRst       (pRst),
            .pInValid   (pInValid),
            .pInReady   (w_rdy[g]),
            .pFilterIn  (pFilterIn),
            .pOutValid  (w_vld[g]),
            .pFilterOut (w_y[g]),
            .pCoefWe    (pCoefWe),
            .pCoefAddr  (pCoefAddr),
            .pCoefData  (pCoefData)
        );
    end

    always #5 pClk = ~pClk;

    int n_cmp = 0;
    int n_bad = 0;

    int m_x [NTAPS];
    int m_c [HALF];

    typedef struct {
        int x;
        int exp_y;
    } vec_t;

    vec_t imp_tbl [26];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint model_y(input int sh);
        longint acc;
        acc = 0;
        for (int k = 0; k < HALF - 1; k++)
            acc += longint'(m_c[k]) * longint'(m_x[k] + m_x[NTAPS-1-k]);
        acc += longint'(m_c[HALF-1]) * longint'(m_x[HALF-1]);
        if (sh > 0) acc += longint'(1) <<< (sh - 1);
        acc = acc >>> sh;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NTAPS; i++) m_x[i] = 0;
        for (int i = 0; i < HALF; i++)  m_c[i] = 0;
    endfunction

    function automatic void model_push(input int x);
        for (int i = NTAPS - 1; i > 0; i--) m_x[i] = m_x[i-1];
        m_x[0] = x;
    endfunction

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s_valid_s%0d", tag, sh_of[g]), longint'(w_vld[g]), 1);
            check($sformatf("%s_y_s%0d", tag, sh_of[g]), longint'(w_y[g]), model_y(sh_of[g]));
        end
    endtask

    task automatic do_reset();
        pRst     = 1'b1;
        pInValid = 1'b1;
        pCoefWe  = 1'b0;
        pFilterIn = 16'sd1234;
        tick();
        tick();
        pRst     = 1'b0;
        pInValid = 1'b0;
        model_clear();
        tick();
        for (int g = 0; g < 3; g++) begin
            check("rst_ready", longint'(w_rdy[g]), 1);
            check("rst_valid", longint'(w_vld[g]), 0);
            check("rst_out", longint'(w_y[g]), 0);
        end
    endtask

    task automatic write_coef(input int addr, input int data);
        pCoefWe   = 1'b1;
        pCoefAddr = AW'(addr);
        pCoefData = CW'(data);
        tick();
        pCoefWe = 1'b0;
        if (addr < HALF) m_c[addr] = data;
    endtask

    // mode 0: plain sample; 1: coefficient write on the accept edge; 2: write during MAC
    task automatic send(input int x, input int mode, input int addr, input int data);
        int w;
        int lat;
        w = 0;
        pInValid  = 1'b1;
        pFilterIn = DW'(x);
        while (!w_rdy[0] && w < 40) begin
            tick();
            w++;
        end
        if (!w_rdy[0]) begin
            check("accept_timeout", 0, 1);
            pInValid = 1'b0;
            return;
        end
        if (mode == 1) begin
            pCoefWe   = 1'b1;
            pCoefAddr = AW'(addr);
            pCoefData = CW'(data);
        end
        tick();
        pInValid = 1'b0;
        pCoefWe  = 1'b0;
        if (mode == 1 && addr < HALF) m_c[addr] = data;
        model_push(x);
        lat = 0;
        do begin
            if (mode == 2) begin
                pCoefWe   = (lat == 2);
                pCoefAddr = AW'(addr);
                pCoefData = CW'(data);
            end
            tick();
            lat++;
        end while (!w_vld[0] && lat < 40);
        pCoefWe = 1'b0;
        check("latency", lat, HALF + 1);
        check_outputs("send");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        pRst = 1'b1; pInValid = 1'b0; pCoefWe = 1'b0;
        pFilterIn = '0; pCoefAddr = '0; pCoefData = '0;
        model_clear();
        for (int i = 0; i < 26; i++) begin
            imp_tbl[i].x     = (i == 0) ? 1 : 0;
            imp_tbl[i].exp_y = (i <= 10) ? i + 1 : ((i <= 20) ? 21 - i : 0);
        end

        // Impulse response
        do_reset();
        for (int k = 0; k < HALF; k++) write_coef(k, k + 1);
        for (int i = 0; i < 26; i++) begin
            send(imp_tbl[i].x, 0, 0, 0);
            check($sformatf("impulse_%0d", i), longint'(w_y[0]), imp_tbl[i].exp_y);
            if (i == 5) begin
                tick(); tick(); tick();
                check("hold_valid", longint'(w_vld[0]), 0);
                check("hold_y", longint'(w_y[0]), imp_tbl[i].exp_y);
            end
        end

        // Saturation
        do_reset();
        for (int k = 0; k < HALF; k++) write_coef(k, 2047);
        for (int i = 0; i < NTAPS; i++) send(32767, 0, 0, 0);
        check("sat_pos", longint'(w_y[0]), 32767);
        for (int i = 0; i < NTAPS; i++) send(-32768, 0, 0, 0);
        check("sat_neg", longint'(w_y[0]), -32768);

        // Rounding on the centre tap
        do_reset();
        write_coef(10, 1);
        send(3, 0, 0, 0);
        for (int i = 0; i < 10; i++) send(0, 0, 0, 0);
        check("round_pos", longint'(w_y[1]), 2);
        send(-3, 0, 0, 0);
        for (int i = 0; i < 10; i++) send(0, 0, 0, 0);
        check("round_neg", longint'(w_y[1]), -1);

        // Backpressure with random data and coefficients
        do_reset();
        for (int k = 0; k < HALF; k++) write_coef(k, int'($urandom_range(0, 4095)) - 2048);
        write_coef(13, 1000);
        begin
            int cyc, prev_acc, n_out, x_now;
            bit will_acc;
            cyc = 0; prev_acc = -1; n_out = 0;
            pInValid = 1'b1;
            while (n_out < 6 && cyc < 200) begin
                x_now     = int'($urandom_range(0, 65535)) - 32768;
                pFilterIn = DW'(x_now);
                will_acc  = w_rdy[0];
                tick();
                cyc++;
                if (will_acc) begin
                    if (prev_acc >= 0) check("bp_spacing", cyc - prev_acc, HALF + 2);
                    prev_acc = cyc;
                    model_push(x_now);
                end
                if (w_vld[0]) begin
                    check("bp_latency", cyc - prev_acc, HALF + 1);
                    check_outputs("bp");
                    n_out++;
                    if (n_out == 6) pInValid = 1'b0;
                end
            end
            pInValid = 1'b0;
            check("bp_outputs", n_out, 6);
        end

        // Coefficient guard: same-edge write applies, MAC-time write is dropped
        send(int'($urandom_range(0, 20000)), 1, 3, -777);
        send(int'($urandom_range(0, 20000)), 2, 0, 1500);
        send(-12345, 0, 0, 0);
        write_coef(12, 999);
        send(4321, 0, 0, 0);

        // Mid-operation reset
        do_reset();
        for (int k = 0; k < HALF; k++) write_coef(k, k + 1);
        for (int i = 0; i < 3; i++) send(1000 * (i + 1), 0, 0, 0);
        pInValid  = 1'b1;
        pFilterIn = 16'sd500;
        tick();
        pInValid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        pRst     = 1'b1;
        pInValid = 1'b1;
        tick();
        pRst     = 1'b0;
        pInValid = 1'b0;
        model_clear();
        tick();
        for (int g = 0; g < 3; g++) begin
            check("mrst_ready", longint'(w_rdy[g]), 1);
            check("mrst_valid", longint'(w_vld[g]), 0);
            check("mrst_out", longint'(w_y[g]), 0);
        end
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (w_vld[0] || w_vld[1] || w_vld[2]) seen++;
            end
            check("mrst_no_strobe", seen, 0);
        end
        for (int k = 0; k < HALF; k++) write_coef(k, k + 1);
        send(0, 0, 0, 0);
        check("mrst_dline_clear", longint'(w_y[0]), 0);
        send(7, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
